// File: rtl/phys_reg_free_list_pkg.sv
// Free-list geometry: capacity, wrap-bit pointer type and pointer-to-slot helper.
package phys_reg_free_list_pkg;

    import rv32i_types::*;

    localparam int FL_DEPTH = NUM_PHYS_REG - NUM_ARCH_REG;
    localparam int FL_IDX_W = $clog2(FL_DEPTH);
    localparam int FL_PTR_W = FL_IDX_W + 1;

    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;

    function automatic fl_idx_t ptr_idx(input fl_ptr_t p);
        return p[FL_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/rv32i_types.sv
// Core-wide types and sizes shared by rename, retirement map, ROB and the free list.
package rv32i_types;

    localparam int NUM_PHYS_REG = 64;
    localparam int NUM_ARCH_REG = 32;
    localparam int PHYS_IDX_W   = $clog2(NUM_PHYS_REG);
    localparam int ARCH_IDX_W   = $clog2(NUM_ARCH_REG);

    typedef logic [PHYS_IDX_W-1:0] phys_idx_t;
    typedef logic [ARCH_IDX_W-1:0] arch_idx_t;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/ROB <-> free-list bundle; master is the pipeline side, slave is the free list.
interface phys_reg_free_list_if;

    logic                            alloc_req;
    logic                            alloc_gnt;
    rv32i_types::phys_idx_t          alloc_pd;
    logic                            commit_valid;
    rv32i_types::arch_idx_t          commit_rd;
    rv32i_types::phys_idx_t          commit_old_pd;
    logic                            flush;
    logic                            empty;
    phys_reg_free_list_pkg::fl_ptr_t free_count;
    logic                            err_overflow;

    modport master (
        output alloc_req, commit_valid, commit_rd, commit_old_pd, flush,
        input  alloc_gnt, alloc_pd, empty, free_count, err_overflow
    );

    modport slave (
        input  alloc_req, commit_valid, commit_rd, commit_old_pd, flush,
        output alloc_gnt, alloc_pd, empty, free_count, err_overflow
    );

endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with speculative and retired heads.
// Latency: grant is combinational; freed tags become grantable the cycle after commit.
// Backpressure: empty suppresses alloc_gnt; flush suppresses it and rewinds to the retired head.
module phys_reg_free_list
    import rv32i_types::*;
    import phys_reg_free_list_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    phys_reg_free_list_if.slave  fl
);

    phys_idx_t mem [FL_DEPTH];
    fl_ptr_t   spec_head;
    fl_ptr_t   ret_head;
    fl_ptr_t   tail;
    logic      err_q;

    fl_ptr_t   free_count;
    fl_ptr_t   ret_head_next;
    fl_ptr_t   tail_next;
    logic      commit_fire;
    logic      full;
    logic      push;
    logic      grant;

    // Every accepted commit moves tail and ret_head together, so the real
    // overflow hazard is pushing while every slot still holds an unallocated tag.
    always_comb begin
        free_count    = tail - spec_head;
        full          = (free_count == fl_ptr_t'(FL_DEPTH));
        commit_fire   = fl.commit_valid && (fl.commit_rd != '0);
        push          = commit_fire && !full;
        grant         = fl.alloc_req && (free_count != '0) && !fl.flush;
        ret_head_next = push ? ret_head + fl_ptr_t'(1) : ret_head;
        tail_next     = push ? tail + fl_ptr_t'(1) : tail;
    end

    assign fl.alloc_gnt    = grant;
    assign fl.alloc_pd     = mem[ptr_idx(spec_head)];
    assign fl.empty        = (free_count == '0);
    assign fl.free_count   = free_count;
    assign fl.err_overflow = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= phys_idx_t'(NUM_ARCH_REG + i);
            end
            spec_head <= '0;
            ret_head  <= '0;
            tail      <= fl_ptr_t'(FL_DEPTH);
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                mem[ptr_idx(tail)] <= fl.commit_old_pd;
            end
            tail     <= tail_next;
            ret_head <= ret_head_next;
            // Recovery lands on the retired head including this cycle's commit.
            if (fl.flush) begin
                spec_head <= ret_head_next;
            end else if (grant) begin
                spec_head <= spec_head + fl_ptr_t'(1);
            end
            if (commit_fire && full) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list with a queue-based free-list model and grant scoreboard.
module tb_phys_reg_free_list;

    logic clk;
    logic rst_n;

    phys_reg_free_list_if fl_if ();

    phys_reg_free_list dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (fl_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [5:0] fl_q   [$];
    logic [5:0] infl_q [$];
    logic [5:0] exp_q  [$];
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        fl_q.delete();
        infl_q.delete();
        exp_q.delete();
        for (int i = 0; i < 32; i++) fl_q.push_back(6'(32 + i));
        m_err = 1'b0;
    endtask

    task automatic drive_idle();
        fl_if.alloc_req     = 1'b0;
        fl_if.commit_valid  = 1'b0;
        fl_if.commit_rd     = '0;
        fl_if.commit_old_pd = '0;
        fl_if.flush         = 1'b0;
    endtask

    // Asserts reset right now (not on an edge) and checks it took effect at once.
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        #1;
        chk("rst_alloc_pd",   fl_if.alloc_pd,     32);
        chk("rst_free_count", fl_if.free_count,   32);
        chk("rst_empty",      fl_if.empty,        0);
        chk("rst_alloc_gnt",  fl_if.alloc_gnt,    0);
        chk("rst_err",        fl_if.err_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic rq, input logic cv, input logic [4:0] rd,
                        input logic [5:0] opd, input logic fls);
        bit p_gnt;
        bit full;
        @(negedge clk);
        fl_if.alloc_req     = rq;
        fl_if.commit_valid  = cv;
        fl_if.commit_rd     = rd;
        fl_if.commit_old_pd = opd;
        fl_if.flush         = fls;
        p_gnt = rq && (fl_q.size() != 0) && !fls;
        if (p_gnt) exp_q.push_back(fl_q[0]);
        #1;
        chk("alloc_gnt",  fl_if.alloc_gnt,    p_gnt);
        chk("free_count", fl_if.free_count,   fl_q.size());
        chk("empty",      fl_if.empty,        fl_q.size() == 0);
        chk("err",        fl_if.err_overflow, m_err);
        if (fl_q.size() != 0) chk("alloc_pd_head", fl_if.alloc_pd, fl_q[0]);
        if (fl_if.alloc_gnt === 1'b1 && exp_q.size() != 0)
            chk("alloc_pd", fl_if.alloc_pd, exp_q.pop_front());
        full = (fl_q.size() == 32);
        if (p_gnt) infl_q.push_back(fl_q.pop_front());
        if (cv && rd != 0) begin
            if (full) m_err = 1'b1;
            else begin
                if (infl_q.size() != 0) void'(infl_q.pop_front());
                fl_q.push_back(opd);
            end
        end
        if (fls) begin
            for (int i = infl_q.size() - 1; i >= 0; i--) fl_q.push_front(infl_q[i]);
            infl_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        drive_idle();
        model_reset();
        #2;
        do_reset();

        // Three grants from reset: 32, 33, 34.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Drain to empty, stall, then a freed tag is granted only the next cycle.
        for (int i = 0; i < 29; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 5'd5, 6'd7, 0);
        step(1, 0, 0, 0, 0);

        // Grant and commit together keep free_count; tag 3 shows up after wrap.
        step(0, 1, 5'd6, 6'd8, 0);
        step(1, 1, 5'd3, 6'd3, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Four grants, one commit, flush: list restored to 32 with head 33.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 5'd1, 6'd1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Flush with a same-cycle commit and request; then drain to see tag 2 last.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 5'd2, 6'd2, 1);
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Commit to x0 is ignored.
        step(0, 1, 5'd0, 6'd9, 0);
        step(0, 0, 0, 0, 0);

        // Commit into a full list: dropped, sticky error, slot not overwritten.
        do_reset();
        step(0, 1, 5'd4, 6'd9, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset mid-sequence, away from any clock edge.
        #2;
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        drive_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
